// File: rtl/lenet_layer_seq.sv
`timescale 1ns/1ps
// lenet_layer_seq: runs NUM_STAGES engines in order (clear, arm, run, gap) from one start pulse.
// Optional per-stage RUN watchdog is built when LENET_SEQ_WDOG_EN is defined.
module lenet_layer_seq #(
  parameter int NUM_STAGES  = 6,
  parameter int IDX_W       = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_finish,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, CLR, ARM, RUN, GAP, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [15:0]      GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  if (NUM_STAGES < 1 || NUM_STAGES > 16 || (1 << IDX_W) < NUM_STAGES ||
      GAP_CYCLES < 0 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_params
    $error("lenet_layer_seq: illegal parameter combination");
  end

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [15:0]           gap_cnt;
  logic                  fin, timeout;
  logic [NUM_STAGES-1:0] rst_nxt, en_nxt;
  logic                  busy_nxt, done_nxt;

  assign cur_stage = idx;

  // Only the finish flag of the stage currently being sequenced matters.
  always_comb begin
    fin = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++)
      if (idx == IDX_W'(i)) fin = stage_finish[i];
  end

`ifdef LENET_SEQ_WDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog;
  logic        err_q;

  assign timeout = (state == RUN) && !fin && !abort && (wdog == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      wdog <= (state == RUN) ? wdog + 16'd1 : '0;
      if (timeout)
        err_q <= 1'b1;
      else if (state == IDLE && start)
        err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      stage_rst <= '0;
      stage_en  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= (state == GAP) ? gap_cnt + 16'd1 : '0;
      stage_rst <= rst_nxt;
      stage_en  <= en_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (start) begin
        state_nxt = CLR;
        idx_nxt   = '0;
      end
      CLR:  state_nxt = ARM;
      ARM:  state_nxt = RUN;
      RUN: begin
        if (timeout)
          state_nxt = IDLE;
        else if (fin) begin
          if (idx == LAST_IDX)
            state_nxt = DONE;
          else if (GAP_CYCLES == 0) begin
            state_nxt = CLR;
            idx_nxt   = idx + 1'b1;
          end else
            state_nxt = GAP;
        end
      end
      GAP: if (gap_cnt == GAP_LAST) begin
        state_nxt = CLR;
        idx_nxt   = idx + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE)
      state_nxt = IDLE;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    rst_nxt = '0;
    en_nxt  = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      rst_nxt[i] = (state_nxt == CLR) && (idx_nxt == IDX_W'(i));
      en_nxt[i]  = (state_nxt == RUN) && (idx_nxt == IDX_W'(i));
    end
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_lenet_layer_seq.sv
`timescale 1ns/1ps
// Directed bench for lenet_layer_seq: 3-stage sequencer with GAP=2 (u_a) and GAP=0 (u_b),
// engine models raise a sticky finish 10 cycles after their enable rises.
module tb_lenet_layer_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start_a, abort_a, start_b, abort_b;
  logic [2:0] fin_a, fin_b, rst_a, en_a, rst_b, en_b;
  logic [2:0] force_a, hang_a, flag_a, flag_b;
  logic [1:0] cur_a, cur_b;
  logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
  int         cnt_a [3];
  int         cnt_b [3];
  int         n_checks = 0;
  int         n_fail = 0;
  int         t = 0;
  int         dones;

  assign fin_a = flag_a | force_a;
  assign fin_b = flag_b;

  lenet_layer_seq #(.NUM_STAGES(3), .IDX_W(2), .GAP_CYCLES(2), .WDOG_CYCLES(20)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .stage_finish(fin_a),
    .stage_rst(rst_a), .stage_en(en_a), .cur_stage(cur_a), .busy(busy_a), .done(done_a), .err(err_a));

  lenet_layer_seq #(.NUM_STAGES(3), .IDX_W(2), .GAP_CYCLES(0), .WDOG_CYCLES(20)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .stage_finish(fin_b),
    .stage_rst(rst_b), .stage_en(en_b), .cur_stage(cur_b), .busy(busy_b), .done(done_b), .err(err_b));

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || rst_a[i]) begin
        flag_a[i] <= 1'b0;
        cnt_a[i]  <= 0;
      end else if (en_a[i] && !hang_a[i]) begin
        cnt_a[i] <= cnt_a[i] + 1;
        if (cnt_a[i] == 9) flag_a[i] <= 1'b1;
      end
      if (rst || rst_b[i]) begin
        flag_b[i] <= 1'b0;
        cnt_b[i]  <= 0;
      end else if (en_b[i]) begin
        cnt_b[i] <= cnt_b[i] + 1;
        if (cnt_b[i] == 9) flag_b[i] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // t counts cycles after the edge that accepted the latest start
  task automatic to(input int target);
    repeat (target - t) @(negedge clk);
    t = target;
  endtask

  task automatic go_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    t = 0;
  endtask

  task automatic go_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    t = 0;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    force_a = '0; hang_a = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset rst", 32'(rst_a), 32'd0);
    check("reset en", 32'(en_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset err", 32'(err_a), 32'd0);
    check("reset cur", 32'(cur_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // normal three-stage run
    go_a();
    check("t1 clr0 rst", 32'(rst_a), 32'b001);
    check("t1 clr0 en", 32'(en_a), 32'b000);
    check("t1 clr0 busy", 32'(busy_a), 32'd1);
    to(1);  check("t1 arm0 rst", 32'(rst_a), 32'b000);
            check("t1 arm0 en", 32'(en_a), 32'b000);
    to(2);  check("t1 run0 en", 32'(en_a), 32'b001);
    to(12); check("t1 run0 hold", 32'(en_a), 32'b001);
    to(13); check("t1 gap0 en", 32'(en_a), 32'b000);
            check("t1 gap0 busy", 32'(busy_a), 32'd1);
    to(14); check("t1 gap0 rst", 32'(rst_a), 32'b000);
    to(15); check("t1 clr1 rst", 32'(rst_a), 32'b010);
            check("t1 clr1 cur", 32'(cur_a), 32'd1);
    to(17); check("t1 run1 en", 32'(en_a), 32'b010);
    to(28); check("t1 gap1 en", 32'(en_a), 32'b000);
    to(30); check("t1 clr2 rst", 32'(rst_a), 32'b100);
            check("t1 clr2 cur", 32'(cur_a), 32'd2);
    to(32); check("t1 run2 en", 32'(en_a), 32'b100);
    to(42); check("t1 run2 nodone", 32'(done_a), 32'd0);
    to(43); check("t1 done", 32'(done_a), 32'd1);
            check("t1 done busy", 32'(busy_a), 32'd1);
            check("t1 done en", 32'(en_a), 32'b000);
    to(44); check("t1 idle done", 32'(done_a), 32'd0);
            check("t1 idle busy", 32'(busy_a), 32'd0);

    // stale finish on stage 0 held through CLR/ARM
    force_a = 3'b001;
    @(negedge clk);
    go_a();
    check("t2 clr0 rst", 32'(rst_a), 32'b001);
    to(1);  check("t2 arm0 en", 32'(en_a), 32'b000);
            check("t2 arm0 busy", 32'(busy_a), 32'd1);
    to(2);  check("t2 run0 en", 32'(en_a), 32'b001);
    to(3);  check("t2 fin0 en", 32'(en_a), 32'b000);
    force_a = 3'b000;
    to(5);  check("t2 clr1 rst", 32'(rst_a), 32'b010);
    to(7);  check("t2 run1 en", 32'(en_a), 32'b010);
    to(18); check("t2 gap1 en", 32'(en_a), 32'b000);
    to(33); check("t2 done", 32'(done_a), 32'd1);
    to(34); check("t2 idle busy", 32'(busy_a), 32'd0);

    // start while busy is ignored
    go_a();
    dones = 0;
    for (int s = 1; s <= 50; s++) begin
      to(s);
      if (s == 19) start_a = 1'b1;
      if (s == 20) start_a = 1'b0;
      dones += int'(done_a);
      if (s == 21) begin
        check("t3 cur after start", 32'(cur_a), 32'd1);
        check("t3 en after start", 32'(en_a), 32'b010);
      end
      if (s == 43) check("t3 done", 32'(done_a), 32'd1);
    end
    check("t3 done count", 32'(dones), 32'd1);

    // abort on the same edge as stage 1 finish
    go_a();
    to(27); abort_a = 1'b1;
    to(28); abort_a = 1'b0;
    check("t4 abort en", 32'(en_a), 32'b000);
    check("t4 abort rst", 32'(rst_a), 32'b000);
    check("t4 abort busy", 32'(busy_a), 32'd0);
    check("t4 abort done", 32'(done_a), 32'd0);
    to(35); check("t4 stay idle", 32'(busy_a), 32'd0);
            check("t4 no done", 32'(done_a), 32'd0);
    go_a();
    check("t4 restart rst", 32'(rst_a), 32'b001);
    check("t4 restart cur", 32'(cur_a), 32'd0);
    to(2);  check("t4 restart en", 32'(en_a), 32'b001);
    to(44); check("t4 restart idle", 32'(busy_a), 32'd0);

    // zero-gap handoff
    go_b();
    check("t5 clr0 rst", 32'(rst_b), 32'b001);
    to(2);  check("t5 run0 en", 32'(en_b), 32'b001);
    to(12); check("t5 run0 hold", 32'(en_b), 32'b001);
    to(13); check("t5 handoff en", 32'(en_b), 32'b000);
            check("t5 handoff rst", 32'(rst_b), 32'b010);
            check("t5 handoff cur", 32'(cur_b), 32'd1);
    to(15); check("t5 run1 en", 32'(en_b), 32'b010);
    to(26); check("t5 clr2 rst", 32'(rst_b), 32'b100);
            check("t5 clr2 en", 32'(en_b), 32'b000);
    to(28); check("t5 run2 en", 32'(en_b), 32'b100);
    to(39); check("t5 done", 32'(done_b), 32'd1);
    to(40); check("t5 idle busy", 32'(busy_b), 32'd0);
            check("t5 err", 32'(err_b), 32'd0);

    // engine 1 never finishes
    hang_a = 3'b010;
    go_a();
    to(36); check("t6 run1 en", 32'(en_a), 32'b010);
            check("t6 run1 err", 32'(err_a), 32'd0);
    to(37);
`ifdef LENET_SEQ_WDOG_EN
    check("t6 wdog en", 32'(en_a), 32'b000);
    check("t6 wdog busy", 32'(busy_a), 32'd0);
    check("t6 wdog err", 32'(err_a), 32'd1);
    check("t6 wdog done", 32'(done_a), 32'd0);
    to(40); check("t6 err sticky", 32'(err_a), 32'd1);
    hang_a = 3'b000;
    go_a();
    check("t6 err cleared", 32'(err_a), 32'd0);
    to(44); check("t6 rerun idle", 32'(busy_a), 32'd0);
`else
    check("t6 waits en", 32'(en_a), 32'b010);
    check("t6 waits busy", 32'(busy_a), 32'd1);
    check("t6 waits err", 32'(err_a), 32'd0);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("t6 abort busy", 32'(busy_a), 32'd0);
    check("t6 abort en", 32'(en_a), 32'b000);
    hang_a = 3'b000;
    @(negedge clk);
`endif

    // synchronous reset mid-run
    go_a();
    to(5);  rst = 1'b1;
    to(6);  rst = 1'b0;
    check("t7 rst busy", 32'(busy_a), 32'd0);
    check("t7 rst en", 32'(en_a), 32'b000);
    check("t7 rst rst", 32'(rst_a), 32'b000);
    check("t7 rst cur", 32'(cur_a), 32'd0);
    check("t7 rst err", 32'(err_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
